seq_logic_unit: RTL

SEQ_LOGIC_UNIT -- requirements
Module: seq_logic_unit

---
 rtl/logic_unit_defs.sv | 23 ++
 rtl/slice_logic.sv | 24 ++
 rtl/seq_logic_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/logic_unit_defs.sv
// Shared encodings for the sliced sequential logic unit: op codes, FSM states
// and the slice-counter width helper.
package logic_unit_defs;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Counter must still be one bit wide when there is a single slice.
  function automatic int unsigned cnt_width(input int unsigned n_slices);
    return (n_slices > 1) ? $clog2(n_slices) : 1;
  endfunction

endpackage

// File: rtl/slice_logic.sv
// Combinational bitwise operator applied to one SLICE-bit chunk of the operands.
module slice_logic
  import logic_unit_defs::*;
#(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  op_e              op,
  output logic [SLICE-1:0] res_c
);

  always_comb begin
    res_c = '0;
    case (op)
      OP_AND:  res_c = x & y;
      OP_OR:   res_c = x | y;
      OP_XOR:  res_c = x ^ y;
      OP_NOR:  res_c = ~(x | y);
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: captures operands, then builds the result
// SLICE bits per clock, LSB slice first, and pulses done once finished.
module seq_logic_unit
  import logic_unit_defs::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned N_SLICES = WIDTH / SLICE;
  localparam int unsigned CNT_W    = cnt_width(N_SLICES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SLICES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SLICE-1:0] a_sl_c;
  logic [SLICE-1:0] b_sl_c;
  logic [SLICE-1:0] slice_res_c;

  // Current slice of the captured operands.
  assign a_sl_c = SLICE'(a_q >> (SLICE * count_q));
  assign b_sl_c = SLICE'(b_q >> (SLICE * count_q));

  slice_logic #(
    .SLICE (SLICE)
  ) u_slice (
    .x     (a_sl_c),
    .y     (b_sl_c),
    .op    (op_q),
    .res_c (slice_res_c)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          op_d     = op_e'(op);
          count_d  = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Unwritten slices are still zero, so OR-ing in the new slice is enough.
        result_d = result_q | (WIDTH'(slice_res_c) << (SLICE * count_q));
        count_d  = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = (result_q == '0);

endmodule
